// File: rtl/cla_seq_adder_16.sv
// ---------------------------------------------------------------------------
// cla_seq_adder_16
//
// Sequential carry-lookahead adder. An accepted start latches the operands
// and the carry-in, then one 4-bit lookahead block is evaluated per clock,
// least-significant nibble first. A running carry register links the
// nibbles. After WIDTH/4 RUN cycles the full sum, carry-out and signed
// overflow are loaded into the output registers and done pulses for one
// cycle.
//
// Parameters
//   WIDTH  operand width in bits (multiple of 4, at least 4), default 16
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset, takes priority over start
//   start  request a new addition (accepted in IDLE or DONE, ignored in RUN)
//   A, B   operands, sampled only on an accepted start
//   c_in   carry into bit 0, sampled only on an accepted start
//   S      registered sum of the last completed addition
//   c_out  registered carry out of the MSB
//   ovf    registered two's-complement overflow
//   busy   high while in RUN
//   done   one-cycle pulse: S, c_out and ovf are newly valid
// ---------------------------------------------------------------------------
module cla_seq_adder_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("cla_seq_adder_16: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [3:0]       w_c;
    logic [3:0]       w_sum_nib;
    logic             w_gprop;
    logic             w_pprop;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_psum_next;
    logic             w_last;

    // Select the nibble addressed by the counter.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int unsigned k = 0; k < NIB; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_nib = r_a[4*k +: 4];
                w_b_nib = r_b[4*k +: 4];
            end
        end
    end

    assign w_g = w_a_nib & w_b_nib;
    assign w_p = w_a_nib ^ w_b_nib;

    // Two-level lookahead carries from the running carry; no bit ripple.
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);

    assign w_pprop = &w_p;
    assign w_gprop = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign w_carry_next = w_gprop | (w_pprop & r_carry);
    assign w_sum_nib    = w_p ^ w_c;
    assign w_last       = (r_cnt == LAST);

    // Partial sum with the current nibble merged in, so the final RUN edge
    // can load S with the complete result in the same cycle.
    always_comb begin
        w_psum_next = r_psum;
        for (int unsigned k = 0; k < NIB; k++) begin
            if (r_cnt == CW'(k)) begin
                w_psum_next[4*k +: 4] = w_sum_nib;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            S       <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_psum  <= w_psum_next;
                    r_carry <= w_carry_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        S       <= w_psum_next;
                        c_out   <= w_carry_next;
                        // Carry into the MSB is w_c[3] of the top nibble.
                        ovf     <= w_c[3] ^ w_carry_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder_16.sv
module tb_cla_seq_adder_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        c_in;
    logic [15:0] S;
    logic        c_out;
    logic        ovf;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    cla_seq_adder_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .c_in  (c_in),
        .S     (S),
        .c_out (c_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete operation: operands are scrambled right after the start
    // edge so that only the latched values can produce the right answer.
    task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic [15:0] es, input logic eco,
                            input logic eov);
        logic [15:0] s0;
        int lat;
        int bc;
        @(negedge clk);
        s0 = S;
        A = a; B = b; c_in = cin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; c_in = ~cin;
        lat = 0;
        bc = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            check({tag, " S_hold"}, 32'(S), 32'(s0));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " busy_cycles"}, 32'(bc), 32'd4);
        check({tag, " S"}, 32'(S), 32'(es));
        check({tag, " c_out"}, 32'(c_out), 32'(eco));
        check({tag, " ovf"}, 32'(ovf), 32'(eov));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t        vecs [7];
        int          lat;
        int          seen_done;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] e;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset S", 32'(S), 32'd0);
        check("reset c_out", 32'(c_out), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);

        for (int i = 0; i < 7; i++) begin
            op_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                     vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // start held high with operands changing during RUN, then a
        // back-to-back start in the DONE cycle.
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!done && lat < 20) begin
            A = 16'($urandom); B = 16'($urandom); c_in = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("held_start latency", 32'(lat), 32'd4);
        check("held_start S", 32'(S), 32'h3333);
        check("held_start c_out", 32'(c_out), 32'd0);
        A = 16'h0001; B = 16'h0001; c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b no_idle_gap busy", 32'(busy), 32'd1);
        check("b2b done_dropped", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("b2b latency", 32'(lat), 32'd4);
        check("b2b S", 32'(S), 32'h0002);
        check("b2b c_out", 32'(c_out), 32'd0);

        // Reset at the second RUN edge aborts the operation.
        @(negedge clk);
        A = 16'hAAAA; B = 16'h5555; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort S", 32'(S), 32'd0);
        check("abort c_out", 32'(c_out), 32'd0);
        check("abort ovf", 32'(ovf), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("abort no_done", 32'(seen_done), 32'd0);
        check("abort S_still_zero", 32'(S), 32'd0);
        op_check("after_abort", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // Random operations against a behavioural sum.
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            e = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            op_check("rand", ra, rb, rc, e[15:0], e[16],
                     (ra[15] == rb[15]) && (e[15] != ra[15]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder_16.md
CLA_SEQ_ADDER_16 -- requirements
Module: cla_seq_adder_16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; it SHALL be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A, sampled only on an accepted start.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B, sampled only on an accepted start.
REQ-007 The block SHALL have port c_in, input, 1 bit: carry into bit 0, sampled only on an accepted start.
REQ-008 The block SHALL have port S, output, WIDTH bits: registered sum of the last completed addition.
REQ-009 The block SHALL have port c_out, output, 1 bit: registered carry out of the MSB.
REQ-010 The block SHALL have port ovf, output, 1 bit: registered two's-complement overflow.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking S, c_out and ovf as newly valid.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, when start=1, the block SHALL latch A, B and c_in into internal registers, clear the nibble counter, and go to RUN on the next edge.
REQ-015 start SHALL be ignored in RUN; the operand registers SHALL NOT change while in RUN.
REQ-016 Each RUN edge SHALL process nibble k, where k is the counter value from 0 to WIDTH/4-1: per-bit G=a&b and P=a^b, lookahead carries from the running carry register, and sum nibble = P^C written to the partial-sum register at bits [4k+3:4k].
REQ-017 Each RUN edge SHALL compute block P_prop as the AND of the four P bits and block G_prop = G3 | P3&G2 | P3&P2&G1 | P3&P2&P1&G0.
REQ-018 Each RUN edge SHALL update the running carry as G_prop | (P_prop & carry); no ripple through the four bit positions is allowed.
REQ-019 On the edge that processes nibble WIDTH/4-1, the block SHALL load S with the full partial sum, c_out with the final carry, and ovf with the carry into the MSB XOR the carry out of the MSB, and SHALL go to DONE.
REQ-020 done SHALL be 1 only in DONE, which lasts exactly one cycle; the next state is IDLE, or RUN if start=1 in that cycle.
REQ-021 Latency: with start sampled at edge N, done SHALL be high in the cycle following edge N+WIDTH/4 (edge N+4 for WIDTH=16).
REQ-022 busy SHALL be 1 exactly in RUN, i.e. for WIDTH/4 cycles per operation.
REQ-023 S, c_out and ovf SHALL hold their values from the start of a new operation until that operation's final RUN edge; they SHALL NOT show partial results.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH, with the carry reported only on c_out.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL go to IDLE and clear S, c_out, ovf, busy, done, the counter, the running carry and the partial sum; rst SHALL take priority over start.
REQ-026 Reset asserted during RUN SHALL abort the operation: no done pulse, and S stays 0 until a later operation completes.

Verification
REQ-027 The bench SHALL cover: A=0x1234, B=0x4321, c_in=0, start pulse -> done exactly 4 edges later, S=0x5555, c_out=0, ovf=0, busy high for 4 cycles.
REQ-028 The bench SHALL cover: A=0xFFFF, B=0x0000, c_in=1 -> S=0x0000, c_out=1, ovf=0, exercising P_prop carry propagation through all nibbles.
REQ-029 The bench SHALL cover: A=0x7FFF, B=0x0001, c_in=0 -> S=0x8000, c_out=0, ovf=1; then A=0x8000, B=0x8000 -> S=0x0000, c_out=1, ovf=1.
REQ-030 The bench SHALL cover: start held high and operands changed during RUN -> result reflects the first operands only; a second start in the DONE cycle (0x0001+0x0001) -> no IDLE gap, done again 4 edges later with S=0x0002.
REQ-031 The bench SHALL cover: rst pulsed at the second RUN edge of 0xAAAA+0x5555 -> no done, all outputs 0, then a new start gives the correct S=0xFFFF, c_out=0.
REQ-032 The bench SHALL cover: random A, B and c_in over at least 1000 operations, checked against a behavioral {c_out,S} = A+B+c_in and the ovf definition in REQ-019.
